// File: rtl/axi_lite_regs.sv
// AXI4-Lite register block: NREG RW registers, a read-only ID word and an optional cycle timer.
// Define AXIL_REGS_TIMER_EN to build the free-running timer readable at offset 0x104.
module axi_lite_regs #(
  parameter int          NREG     = 8,
  parameter int          ADDR_W   = 12,
  parameter logic [31:0] ID_VALUE = 32'hC0DE_0001
) (
  input  logic                 axi_aclk,
  input  logic                 axi_aresetn,
  input  logic [ADDR_W-1:0]    s_axi_awaddr,
  input  logic                 s_axi_awvalid,
  output logic                 s_axi_awready,
  input  logic [31:0]          s_axi_wdata,
  input  logic [3:0]           s_axi_wstrb,
  input  logic                 s_axi_wvalid,
  output logic                 s_axi_wready,
  output logic [1:0]           s_axi_bresp,
  output logic                 s_axi_bvalid,
  input  logic                 s_axi_bready,
  input  logic [ADDR_W-1:0]    s_axi_araddr,
  input  logic                 s_axi_arvalid,
  output logic                 s_axi_arready,
  output logic [31:0]          s_axi_rdata,
  output logic [1:0]           s_axi_rresp,
  output logic                 s_axi_rvalid,
  input  logic                 s_axi_rready,
  output logic [NREG*32-1:0]   reg_out
);

  localparam int IDX_W = ADDR_W - 2;
  localparam logic [IDX_W-1:0] NREG_IDX = IDX_W'(NREG);
  localparam logic [IDX_W-1:0] ID_IDX   = IDX_W'(32'd64);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_COLLECT = 2'd0,
    W_COMMIT  = 2'd1,
    W_RESP    = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RESP = 1'b1
  } r_state_t;

  function automatic logic [31:0] merge_strb(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  w_state_t           w_state_r, w_next_s;
  r_state_t           r_state_r, r_next_s;
  logic               aw_held_r, w_held_r, aw_held_s, w_held_s;
  logic [IDX_W-1:0]   wr_idx_r;
  logic [31:0]        wdata_r;
  logic [3:0]         wstrb_r;
  logic               awready_r, wready_r, awready_s, wready_s;
  logic               bvalid_r;
  logic [1:0]         bresp_r;
  logic               aw_take_s, w_take_s, commit_s, clear_s, wr_ok_s;
  logic               arready_r, arready_s, ar_take_s;
  logic               rvalid_r;
  logic [31:0]        rdata_r, rd_data_s;
  logic [1:0]         rresp_r, rd_resp_s;
  logic [IDX_W-1:0]   rd_idx_s;
  logic [31:0]        regs_r [NREG];
  logic               unused_s;

  assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};
  assign wr_ok_s  = (wr_idx_r < NREG_IDX);
  assign rd_idx_s = s_axi_araddr[ADDR_W-1:2];

  // Write FSM next-state, handshake acceptance and next ready values
  always_comb begin
    w_next_s  = w_state_r;
    aw_take_s = 1'b0;
    w_take_s  = 1'b0;
    commit_s  = 1'b0;
    clear_s   = 1'b0;
    case (w_state_r)
      W_COLLECT: begin
        aw_take_s = s_axi_awvalid & awready_r;
        w_take_s  = s_axi_wvalid & wready_r;
        if (aw_held_r & w_held_r) w_next_s = W_COMMIT;
        else                      w_next_s = W_COLLECT;
      end
      W_COMMIT: begin
        commit_s = 1'b1;
        w_next_s = W_RESP;
      end
      W_RESP: begin
        if (s_axi_bready) begin
          clear_s  = 1'b1;
          w_next_s = W_COLLECT;
        end else begin
          w_next_s = W_RESP;
        end
      end
      default: w_next_s = W_COLLECT;
    endcase
    aw_held_s = clear_s ? 1'b0 : (aw_held_r | aw_take_s);
    w_held_s  = clear_s ? 1'b0 : (w_held_r | w_take_s);
    awready_s = (w_next_s == W_COLLECT) & ~aw_held_s;
    wready_s  = (w_next_s == W_COLLECT) & ~w_held_s;
  end

  // Write FSM state, holding registers and B channel
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      w_state_r <= W_COLLECT;
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      wr_idx_r  <= '0;
      wdata_r   <= 32'h0;
      wstrb_r   <= 4'h0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bvalid_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
    end else begin
      w_state_r <= w_next_s;
      aw_held_r <= aw_held_s;
      w_held_r  <= w_held_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      if (aw_take_s) wr_idx_r <= s_axi_awaddr[ADDR_W-1:2];
      if (w_take_s) begin
        wdata_r <= s_axi_wdata;
        wstrb_r <= s_axi_wstrb;
      end
      if (commit_s) begin
        bvalid_r <= 1'b1;
        bresp_r  <= wr_ok_s ? RESP_OKAY : RESP_SLVERR;
      end else if (clear_s) begin
        bvalid_r <= 1'b0;
        bresp_r  <= RESP_OKAY;
      end
    end
  end

  // Register file: byte-masked update on the commit cycle only
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      for (int i = 0; i < NREG; i++) regs_r[i] <= 32'h0;
    end else if (commit_s && wr_ok_s) begin
      for (int i = 0; i < NREG; i++) begin
        if (wr_idx_r == IDX_W'(i)) regs_r[i] <= merge_strb(regs_r[i], wdata_r, wstrb_r);
      end
    end
  end

`ifdef AXIL_REGS_TIMER_EN
  localparam logic [IDX_W-1:0] TIMER_IDX = IDX_W'(32'd65);
  logic [31:0] timer_r;

  // Free-running cycle timer, wraps naturally
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) timer_r <= 32'h0;
    else              timer_r <= timer_r + 32'd1;
  end
`endif

  // Read FSM next-state and address decode
  always_comb begin
    r_next_s  = r_state_r;
    ar_take_s = 1'b0;
    rd_data_s = 32'h0;
    rd_resp_s = RESP_SLVERR;
    case (r_state_r)
      R_IDLE: begin
        ar_take_s = s_axi_arvalid & arready_r;
        if (ar_take_s) r_next_s = R_RESP;
        else           r_next_s = R_IDLE;
      end
      R_RESP: begin
        if (s_axi_rready) r_next_s = R_IDLE;
        else              r_next_s = R_RESP;
      end
      default: r_next_s = R_IDLE;
    endcase
    if (rd_idx_s < NREG_IDX) begin
      rd_resp_s = RESP_OKAY;
      for (int i = 0; i < NREG; i++) begin
        if (rd_idx_s == IDX_W'(i)) rd_data_s = regs_r[i];
      end
    end else if (rd_idx_s == ID_IDX) begin
      rd_data_s = ID_VALUE;
      rd_resp_s = RESP_OKAY;
`ifdef AXIL_REGS_TIMER_EN
    end else if (rd_idx_s == TIMER_IDX) begin
      rd_data_s = timer_r;
      rd_resp_s = RESP_OKAY;
`endif
    end else begin
      rd_data_s = 32'h0;
      rd_resp_s = RESP_SLVERR;
    end
    arready_s = (r_next_s == R_IDLE);
  end

  // Read FSM state and R channel; data is captured on the AR handshake
  always_ff @(posedge axi_aclk) begin
    if (!axi_aresetn) begin
      r_state_r <= R_IDLE;
      arready_r <= 1'b0;
      rvalid_r  <= 1'b0;
      rdata_r   <= 32'h0;
      rresp_r   <= RESP_OKAY;
    end else begin
      r_state_r <= r_next_s;
      arready_r <= arready_s;
      if (ar_take_s) begin
        rvalid_r <= 1'b1;
        rdata_r  <= rd_data_s;
        rresp_r  <= rd_resp_s;
      end else if ((r_state_r == R_RESP) && s_axi_rready) begin
        rvalid_r <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_reg_out
    assign reg_out[32*g +: 32] = regs_r[g];
  end

  assign s_axi_awready = awready_r;
  assign s_axi_wready  = wready_r;
  assign s_axi_bvalid  = bvalid_r;
  assign s_axi_bresp   = bresp_r;
  assign s_axi_arready = arready_r;
  assign s_axi_rvalid  = rvalid_r;
  assign s_axi_rdata   = rdata_r;
  assign s_axi_rresp   = rresp_r;

endmodule
